// File: rtl/nand_page_read_seq.sv
// ONFI page-read sequencer driving the nand_master primitive interface.
// Optional macro NAND_PAGE_READ_SEQ_TIMEOUT_EN bounds the busy wait and reports err.
module nand_page_read_seq #(
  parameter logic [7:0] OP_CMD    = 8'h01,
  parameter logic [7:0] OP_ADDR   = 8'h02,
  parameter logic [7:0] OP_READ   = 8'h03,
  parameter logic [7:0] OP_WAITRB = 8'h04,
  parameter int         LEN_W     = 12,
  parameter int         TMO_W     = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      col_addr,
  input  logic [23:0]      row_addr,
  input  logic [LEN_W-1:0] byte_len,
  output logic             busy_o,
  output logic             done,
  output logic             err,
  output logic [7:0]       m_cmd_in,
  output logic [7:0]       m_data_in,
  output logic             m_activate,
  input  logic             m_busy,
  input  logic [7:0]       m_data_out,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_PUSH, S_FIN} state_t;

  localparam logic [3:0] STEP_WAITRB = 4'd7;
  localparam logic [3:0] STEP_READ   = 4'd8;

  state_t           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0]      col_q, col_d;
  logic [23:0]      row_q, row_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       dat_q, dat_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef NAND_PAGE_READ_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  function automatic logic [7:0] step_cmd(input logic [3:0] step);
    case (step)
      4'd0, 4'd6:  step_cmd = OP_CMD;
      4'd7:        step_cmd = OP_WAITRB;
      4'd8:        step_cmd = OP_READ;
      default:     step_cmd = OP_ADDR;
    endcase
  endfunction

  function automatic logic [7:0] step_dat(input logic [3:0] step, input logic [15:0] col,
                                          input logic [23:0] row);
    case (step)
      4'd1:    step_dat = col[7:0];
      4'd2:    step_dat = col[15:8];
      4'd3:    step_dat = row[7:0];
      4'd4:    step_dat = row[15:8];
      4'd5:    step_dat = row[23:16];
      4'd6:    step_dat = 8'h30;
      default: step_dat = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    rem_d      = rem_q;
    col_d      = col_q;
    row_d      = row_q;
    cmd_d      = cmd_q;
    dat_d      = dat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef NAND_PAGE_READ_SEQ_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d   = col_addr;
          row_d   = row_addr;
          rem_d   = byte_len;
          step_d  = 4'd0;
          busy_d  = 1'b1;
          cmd_d   = step_cmd(4'd0);
          dat_d   = step_dat(4'd0, col_addr, row_addr);
          state_d = S_ISSUE;
`ifdef NAND_PAGE_READ_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_ISSUE: if (!m_busy) state_d = S_GUARD;
      S_GUARD: begin
        state_d = S_WAIT;
`ifdef NAND_PAGE_READ_SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (!m_busy) begin
          if (step_q == STEP_READ) begin
            rd_data_d  = m_data_out;
            rd_valid_d = 1'b1;
            cmd_d      = 8'h00;
            state_d    = S_PUSH;
          end else if (step_q < STEP_WAITRB) begin
            step_d  = step_q + 4'd1;
            cmd_d   = step_cmd(step_q + 4'd1);
            dat_d   = step_dat(step_q + 4'd1, col_q, row_q);
            state_d = S_ISSUE;
          end else if (rem_q == '0) begin
            cmd_d   = 8'h00;
            dat_d   = 8'h00;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            step_d  = STEP_READ;
            cmd_d   = OP_READ;
            dat_d   = 8'h00;
            state_d = S_ISSUE;
          end
        end
`ifdef NAND_PAGE_READ_SEQ_TIMEOUT_EN
        else if (&tmo_q) begin
          // Device never released busy: abandon the page and report it
          err_d   = 1'b1;
          cmd_d   = 8'h00;
          dat_d   = 8'h00;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_PUSH: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rem_d      = rem_q - 1'b1;
          if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            cmd_d   = OP_READ;
            dat_d   = 8'h00;
            state_d = S_ISSUE;
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      rem_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      cmd_q      <= '0;
      dat_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef NAND_PAGE_READ_SEQ_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      rem_q      <= rem_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cmd_q      <= cmd_d;
      dat_q      <= dat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef NAND_PAGE_READ_SEQ_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  // Launch is decoded from the state flop so it falls with reset and never repeats
  assign m_activate = (state_q == S_ISSUE) && !m_busy;
  assign m_cmd_in   = cmd_q;
  assign m_data_in  = dat_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy_o     = busy_q;
  assign done       = done_q;
`ifdef NAND_PAGE_READ_SEQ_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_nand_page_read_seq.sv
// Directed bench for nand_page_read_seq with a 3-cycle-busy nand_master model.
module tb_nand_page_read_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] col_addr = '0;
  logic [23:0] row_addr = '0;
  logic [11:0] byte_len = '0;
  logic        busy_o, done, err, m_activate, rd_valid;
  logic [7:0]  m_cmd_in, m_data_in, rd_data;
  logic        m_busy = 1'b0;
  logic [7:0]  m_data_out = '0;
  logic        rd_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  nand_page_read_seq dut (
    .clk(clk), .reset(reset), .start(start), .col_addr(col_addr), .row_addr(row_addr),
    .byte_len(byte_len), .busy_o(busy_o), .done(done), .err(err),
    .m_cmd_in(m_cmd_in), .m_data_in(m_data_in), .m_activate(m_activate),
    .m_busy(m_busy), .m_data_out(m_data_out), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  // nand_master model and output monitors
  logic [7:0] log_cmd [0:255];
  logic [7:0] log_dat [0:255];
  logic [7:0] beat_dat [0:255];
  int n_act = 0, n_rd = 0, n_beat = 0, n_done = 0;
  int bcnt = 0;

  always @(posedge clk) begin
    if (m_activate) begin
      log_cmd[n_act[7:0]] <= m_cmd_in;
      log_dat[n_act[7:0]] <= m_data_in;
      n_act  <= n_act + 1;
      m_busy <= 1'b1;
      bcnt   <= 2;
      if (m_cmd_in == 8'h03) begin
        m_data_out <= 8'hA0 + 8'(n_rd);
        n_rd <= n_rd + 1;
      end
    end else if (m_busy) begin
      if (bcnt == 0) m_busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end
    if (rd_valid && rd_ready) begin
      beat_dat[n_beat[7:0]] <= rd_data;
      n_beat <= n_beat + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic do_start(input logic [15:0] c, input logic [23:0] r, input logic [11:0] l);
    @(negedge clk);
    col_addr = c; row_addr = r; byte_len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit tmo, output bit drop);
    tmo = 1'b1; drop = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin tmo = 1'b0; break; end
      if (!busy_o) drop = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy_o, done, err, m_cmd_in, m_data_in, m_activate, rd_data, rd_valid} !== 28'h0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b cmd=%h dat=%h act=%b rd=%h vld=%b, want all 0",
               busy_o, done, err, m_cmd_in, m_data_in, m_activate, rd_data, rd_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, m_activate, rd_valid, done} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b act=%b vld=%b done=%b, want 0000",
               busy_o, m_activate, rd_valid, done);
    end
  endtask

  task automatic test_basic_read;
    logic [7:0] exp_cmd [0:11];
    logic [7:0] exp_dat [0:11];
    logic [7:0] exp;
    int a0, b0, r0, d0;
    bit tmo, drop;
    exp_cmd = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01, 8'h04, 8'h03, 8'h03, 8'h03, 8'h03};
    exp_dat = '{8'h00, 8'h23, 8'h01, 8'h78, 8'h56, 8'h04, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    a0 = n_act; b0 = n_beat; r0 = n_rd; d0 = n_done;
    do_start(16'h0123, 24'h045678, 12'd4);
    wait_done(400, tmo, drop);
    repeat (2) @(negedge clk);
    checks++;
    if (tmo || drop) begin
      failures++;
      $display("FAIL basic_done_busy: timeout=%b busy_dropped=%b, want 0 0", tmo, drop);
    end
    checks++;
    if (n_act - a0 != 12) begin
      failures++;
      $display("FAIL basic_act_count: got %0d want 12", n_act - a0);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (log_cmd[8'(a0 + i)] !== exp_cmd[i] || log_dat[8'(a0 + i)] !== exp_dat[i]) begin
        failures++;
        $display("FAIL basic_op%0d: got cmd=%h dat=%h want cmd=%h dat=%h", i,
                 log_cmd[8'(a0 + i)], log_dat[8'(a0 + i)], exp_cmd[i], exp_dat[i]);
      end
    end
    checks++;
    if (n_beat - b0 != 4) begin
      failures++;
      $display("FAIL basic_beats: got %0d want 4", n_beat - b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp = 8'hA0 + 8'(r0 + k);
      checks++;
      if (beat_dat[8'(b0 + k)] !== exp) begin
        failures++;
        $display("FAIL basic_byte%0d: got %h want %h", k, beat_dat[8'(b0 + k)], exp);
      end
    end
    checks++;
    if (n_done - d0 != 1 || busy_o !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: dones=%0d busy=%b err=%b want 1 0 0", n_done - d0, busy_o, err);
    end
  endtask

  task automatic test_zero_len;
    int a0, b0, d0;
    bit tmo, drop;
    a0 = n_act; b0 = n_beat; d0 = n_done;
    do_start(16'h0BCD, 24'h0000EF, 12'd0);
    wait_done(300, tmo, drop);
    repeat (2) @(negedge clk);
    checks++;
    if (tmo || n_act - a0 != 8 || n_beat - b0 != 0 || n_done - d0 != 1) begin
      failures++;
      $display("FAIL zero_len: timeout=%b acts=%0d beats=%0d dones=%0d want 0 8 0 1",
               tmo, n_act - a0, n_beat - b0, n_done - d0);
    end
    checks++;
    if (log_cmd[8'(a0 + 7)] !== 8'h04) begin
      failures++;
      $display("FAIL zero_len_last_op: got %h want 04", log_cmd[8'(a0 + 7)]);
    end
  endtask

  task automatic test_backpressure;
    int a0, b0, r0, a_stall;
    logic [7:0] held, exp;
    bit tmo, drop, bad, seen;
    a0 = n_act; b0 = n_beat; r0 = n_rd;
    rd_ready = 1'b1;
    do_start(16'h0010, 24'h000020, 12'd3);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (n_beat - b0 == 1) seen = 1'b1;
    end
    rd_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
    end
    held = rd_data; a_stall = n_act; bad = !seen;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_valid !== 1'b1 || rd_data !== held) bad = 1'b1;
    end
    exp = 8'hA0 + 8'(r0 + 1);
    checks++;
    if (bad || held !== exp) begin
      failures++;
      $display("FAIL stall_hold: held=%h want %h, unstable_or_missing=%b", held, exp, bad);
    end
    checks++;
    if (n_act != a_stall) begin
      failures++;
      $display("FAIL stall_no_issue: acts during stall %0d want 0", n_act - a_stall);
    end
    rd_ready = 1'b1;
    wait_done(300, tmo, drop);
    repeat (2) @(negedge clk);
    checks++;
    if (tmo || n_beat - b0 != 3 || n_act - a0 != 11) begin
      failures++;
      $display("FAIL stall_totals: timeout=%b beats=%0d acts=%0d want 0 3 11",
               tmo, n_beat - b0, n_act - a0);
    end
    for (int k = 0; k < 3; k++) begin
      exp = 8'hA0 + 8'(r0 + k);
      checks++;
      if (beat_dat[8'(b0 + k)] !== exp) begin
        failures++;
        $display("FAIL stall_byte%0d: got %h want %h", k, beat_dat[8'(b0 + k)], exp);
      end
    end
  endtask

  task automatic test_start_ignored;
    int a0, b0, d0;
    bit seen;
    a0 = n_act; b0 = n_beat; d0 = n_done;
    do_start(16'h1111, 24'h222222, 12'd2);
    repeat (5) @(negedge clk);
    col_addr = 16'hFFFF; byte_len = 12'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (!seen || n_act - a0 != 10 || n_beat - b0 != 2 || n_done - d0 != 1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored: done_seen=%b acts=%0d beats=%0d dones=%0d busy=%b want 1 10 2 1 0",
               seen, n_act - a0, n_beat - b0, n_done - d0, busy_o);
    end
    checks++;
    if (log_dat[8'(a0 + 1)] !== 8'h11) begin
      failures++;
      $display("FAIL start_ignored_col: got %h want 11", log_dat[8'(a0 + 1)]);
    end
  endtask

  task automatic test_reset_mid;
    int a0, d0, b0, r0;
    logic [7:0] exp;
    bit seen, tmo, drop;
    a0 = n_act; d0 = n_done;
    do_start(16'h0042, 24'h000099, 12'd3);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (n_act - a0 == 10) seen = 1'b1;
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (!seen || {busy_o, done, err, m_cmd_in, m_data_in, m_activate, rd_data, rd_valid} !== 28'h0) begin
      failures++;
      $display("FAIL reset_mid: reached=%b busy=%b done=%b cmd=%h dat=%h act=%b rd=%h vld=%b want all 0",
               seen, busy_o, done, m_cmd_in, m_data_in, m_activate, rd_data, rd_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20 && m_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (n_done != d0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_done: dones=%0d busy=%b want 0 0", n_done - d0, busy_o);
    end
    a0 = n_act; b0 = n_beat; r0 = n_rd; d0 = n_done;
    do_start(16'h0042, 24'h000099, 12'd2);
    wait_done(300, tmo, drop);
    repeat (2) @(negedge clk);
    checks++;
    if (tmo || drop || n_act - a0 != 10 || n_beat - b0 != 2 || n_done - d0 != 1) begin
      failures++;
      $display("FAIL after_reset_run: timeout=%b drop=%b acts=%0d beats=%0d dones=%0d want 0 0 10 2 1",
               tmo, drop, n_act - a0, n_beat - b0, n_done - d0);
    end
    exp = 8'hA0 + 8'(r0 + 1);
    checks++;
    if (beat_dat[8'(b0 + 1)] !== exp) begin
      failures++;
      $display("FAIL after_reset_byte: got %h want %h", beat_dat[8'(b0 + 1)], exp);
    end
  endtask

  task automatic test_max_len;
    int a0, b0, d0;
    bit tmo, drop;
    a0 = n_act; b0 = n_beat; d0 = n_done;
    do_start(16'h0000, 24'h000001, 12'hFFF);
    wait_done(40000, tmo, drop);
    repeat (2) @(negedge clk);
    checks++;
    if (tmo || drop || n_beat - b0 != 4095 || n_act - a0 != 4103 || n_done - d0 != 1) begin
      failures++;
      $display("FAIL max_len: timeout=%b drop=%b beats=%0d acts=%0d dones=%0d want 0 0 4095 4103 1",
               tmo, drop, n_beat - b0, n_act - a0, n_done - d0);
    end
  endtask

  initial begin
    test_reset;
    test_basic_read;
    test_zero_len;
    test_backpressure;
    test_start_ignored;
    test_reset_mid;
    test_max_len;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
